// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to 4-digit packed BCD converter.
// Converts one bit per clock; results saturate to 9999 with ovf set.
module bin2bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd,
   output logic             ovf
);
   localparam int WW = 16 + BIN_W;
   localparam int CW = $clog2(BIN_W);
   typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
   state_t          r_state;
   state_t          w_state;
   logic [WW-1:0]   r_work;
   logic [CW-1:0]   r_cnt;
   logic            r_ovf_pend;
   logic            r_done;
   logic [15:0]     r_bcd;
   logic            r_ovf;
   logic [15:0]     w_adj;
   logic [WW-1:0]   w_shift;
   logic            w_last;
   logic            w_load;
   logic            w_fin;
   // Add-3 on every BCD nibble >= 5, evaluated on pre-add values.
   for (genvar g = 0; g < 4; g++) begin : g_adj
      assign w_adj[4*g +: 4] = (r_work[BIN_W + 4*g +: 4] >= 4'd5) ?
                               r_work[BIN_W + 4*g +: 4] + 4'd3 :
                               r_work[BIN_W + 4*g +: 4];
   end
   assign w_shift = {w_adj[14:0], r_work[BIN_W-1:0], 1'b0};
   assign w_last  = (r_cnt == CW'(BIN_W - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state;
   end
   always_comb begin
      w_state = r_state;
      if (r_state == S_IDLE) w_state = start ? S_SHIFT : S_IDLE;
      else                   w_state = w_last ? S_IDLE : S_SHIFT;
   end
   always_comb begin
      w_load = (r_state == S_IDLE) && start;
      w_fin  = (r_state == S_SHIFT) && w_last;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work     <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= 16'h0000;
         r_ovf      <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_load) begin
            r_work     <= {16'h0000, bin};
            r_cnt      <= '0;
            r_ovf_pend <= (32'(bin) > 32'd9999);
         end else if (r_state == S_SHIFT) begin
            r_work <= w_shift;
            r_cnt  <= r_cnt + 1'b1;
         end
         if (w_fin) begin
            r_bcd <= r_ovf_pend ? 16'h9999 : w_shift[WW-1 -: 16];
            r_ovf <= r_ovf_pend;
         end
      end
   end
   assign busy = (r_state == S_SHIFT);
   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;
endmodule
